// File: rtl/imem_responder_pkg.sv
// Shared constants and FSM encoding for the instruction main-memory responder.
// Sizes match an 8-bit byte address split into 16-byte (128-bit) blocks.
package imem_responder_pkg;

  localparam int unsigned IMEM_BLOCK_ADDR_SIZE = 4;
  localparam int unsigned IBLOCK_SIZE_BITS     = 128;
  localparam int unsigned IADDR_SIZE           = 8;
  localparam int unsigned IMEM_LATENCY         = 10;

  // Wide enough for the largest legal latency preset (254).
  localparam int unsigned IMEM_CNT_W = 8;

  typedef enum logic [1:0] {
    ImemIdle  = 2'd0,
    ImemBusy  = 2'd1,
    ImemReady = 2'd2
  } imem_state_e;

  // Counter preload on acceptance: the capture edge is the one where the count hits zero.
  function automatic logic [IMEM_CNT_W-1:0] latency_preset(input int unsigned lat);
    return IMEM_CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Block-read handshake and preload port between the cache controller and the responder.
// The master side drives requests and preloads; the slave side answers.
interface imem_responder_if
  import imem_responder_pkg::*;
#(
  parameter int unsigned BLOCK_ADDR_W = IMEM_BLOCK_ADDR_SIZE,
  parameter int unsigned BLOCK_W      = IBLOCK_SIZE_BITS
) ();

  logic                    memRen;
  logic [BLOCK_ADDR_W-1:0] BlockAddr;
  logic                    memReadReady;
  logic [BLOCK_W-1:0]      memDout;
  logic                    loadWen;
  logic [BLOCK_ADDR_W-1:0] loadAddr;
  logic [BLOCK_W-1:0]      loadData;
  logic                    busy;

  modport master (
    output memRen,
    output BlockAddr,
    output loadWen,
    output loadAddr,
    output loadData,
    input  memReadReady,
    input  memDout,
    input  busy
  );

  modport slave (
    input  memRen,
    input  BlockAddr,
    input  loadWen,
    input  loadAddr,
    input  loadData,
    output memReadReady,
    output memDout,
    output busy
  );

endinterface

// File: rtl/imem_array.sv
// Block storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; a same-edge write is seen by the reader only afterwards.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int unsigned AddrW = IMEM_BLOCK_ADDR_SIZE,
  parameter int unsigned DataW = IBLOCK_SIZE_BITS
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Instruction main-memory slave: accepts a block read, waits LATENCY cycles, then
// presents the block with memReadReady until the controller drops memRen.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned BLOCK_ADDR_W = IMEM_BLOCK_ADDR_SIZE,
  parameter int unsigned BLOCK_W      = IBLOCK_SIZE_BITS,
  parameter int unsigned LATENCY      = IMEM_LATENCY
) (
  input  logic                   clock,
  input  logic                   reset,
  imem_responder_if.slave        bus
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..255");
  end

  imem_state_e             state_q, state_d;
  logic [IMEM_CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
  logic                    ready_q, ready_d;
  logic [BLOCK_W-1:0]      dout_q, dout_d;
  logic                    busy_q, busy_d;
  logic [BLOCK_W-1:0]      rd_data;

  imem_array #(
    .AddrW (BLOCK_ADDR_W),
    .DataW (BLOCK_W)
  ) u_array (
    .clk_i   (clock),
    .we_i    (bus.loadWen),
    .waddr_i (bus.loadAddr),
    .wdata_i (bus.loadData),
    .raddr_i (addr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    case (state_q)
      ImemIdle: begin
        if (bus.memRen) begin
          addr_d  = bus.BlockAddr;
          cnt_d   = latency_preset(LATENCY);
          busy_d  = 1'b1;
          state_d = ImemBusy;
        end
      end
      ImemBusy: begin
        if (!bus.memRen) begin
          // Controller withdrew the request: abandon it without a ready pulse.
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ImemIdle;
        end else if (cnt_q == '0) begin
          // Capture pre-write data; a load on this same edge lands afterwards.
          dout_d  = rd_data;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ImemReady;
        end else begin
          cnt_d = cnt_q - IMEM_CNT_W'(1);
        end
      end
      ImemReady: begin
        if (!bus.memRen) begin
          ready_d = 1'b0;
          dout_d  = '0;
          state_d = ImemIdle;
        end
      end
      default: begin
        state_d = ImemIdle;
        cnt_d   = '0;
        ready_d = 1'b0;
        dout_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ImemIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.memReadReady = ready_q;
  assign bus.memDout      = dout_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a LATENCY=10 and a LATENCY=1 instance driven in lockstep and
// checked every cycle against a time-based request model, plus directed and table sequences.
module tb_imem_responder;

  localparam int LAT_A = 10;
  localparam int LAT_B = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         ren;
  logic [3:0]   baddr;
  logic         lwen;
  logic [3:0]   laddr;
  logic [127:0] ldata;

  always #5 clk = ~clk;

  imem_responder_if #(.BLOCK_ADDR_W(4), .BLOCK_W(128)) bus_a ();
  imem_responder_if #(.BLOCK_ADDR_W(4), .BLOCK_W(128)) bus_b ();

  assign bus_a.memRen    = ren;
  assign bus_a.BlockAddr = baddr;
  assign bus_a.loadWen   = lwen;
  assign bus_a.loadAddr  = laddr;
  assign bus_a.loadData  = ldata;
  assign bus_b.memRen    = ren;
  assign bus_b.BlockAddr = baddr;
  assign bus_b.loadWen   = lwen;
  assign bus_b.loadAddr  = laddr;
  assign bus_b.loadData  = ldata;

  imem_responder #(.BLOCK_ADDR_W(4), .BLOCK_W(128), .LATENCY(LAT_A)) u_dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (bus_a)
  );

  imem_responder #(.BLOCK_ADDR_W(4), .BLOCK_W(128), .LATENCY(LAT_B)) u_dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: memory contents plus, per instance, the cycle a request was accepted.
  logic [127:0] mm [16];
  int           cyc = 0;
  int           acc_c    [2];
  logic [3:0]   acc_addr [2];
  logic         exp_rdy  [2];
  logic         exp_busy [2];
  logic [127:0] exp_dout [2];
  int           lat      [2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int el;
      if (rst) begin
        acc_c[k]    = -1;
        exp_rdy[k]  = 1'b0;
        exp_busy[k] = 1'b0;
        exp_dout[k] = '0;
      end else if (acc_c[k] >= 0) begin
        if (!ren) begin
          acc_c[k]    = -1;
          exp_rdy[k]  = 1'b0;
          exp_busy[k] = 1'b0;
          exp_dout[k] = '0;
        end else begin
          el = cyc - acc_c[k];
          if (el == lat[k]) begin
            exp_rdy[k]  = 1'b1;
            exp_dout[k] = mm[acc_addr[k]];
          end
          exp_busy[k] = (el < lat[k]);
        end
      end else if (ren) begin
        acc_c[k]    = cyc;
        acc_addr[k] = baddr;
        exp_busy[k] = 1'b1;
      end
    end
    if (lwen) mm[laddr] = ldata;
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("a_ready", {127'd0, bus_a.memReadReady}, {127'd0, exp_rdy[0]});
    check("a_busy",  {127'd0, bus_a.busy},         {127'd0, exp_busy[0]});
    check("a_dout",  bus_a.memDout,                exp_dout[0]);
    check("b_ready", {127'd0, bus_b.memReadReady}, {127'd0, exp_rdy[1]});
    check("b_busy",  {127'd0, bus_b.busy},         {127'd0, exp_busy[1]});
    check("b_dout",  bus_b.memDout,                exp_dout[1]);
  endtask

  task automatic load(input logic [3:0] a, input logic [127:0] d);
    lwen  = 1'b1;
    laddr = a;
    ldata = d;
    step();
    lwen  = 1'b0;
  endtask

  // Steps until instance A shows ready; returns the number of steps taken (bounded).
  task automatic wait_ready_a(output int k);
    k = 0;
    while (!bus_a.memReadReady && k < 40) begin
      step();
      k++;
    end
  endtask

  typedef struct {
    logic         ren;
    logic [3:0]   addr;
    logic         rdy;
    logic         busy;
    logic [127:0] dout;
  } vec_t;

  localparam logic [127:0] D_AA = {8'hAA, 120'd0};
  localparam logic [127:0] D_7  = 128'h7777_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] D_8  = 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [127:0] ONES = '1;

  initial begin
    vec_t tbl [8];
    int   k;
    logic seen;

    lat[0] = LAT_A;
    lat[1] = LAT_B;
    for (int i = 0; i < 2; i++) begin
      acc_c[i] = -1; acc_addr[i] = '0; exp_rdy[i] = 1'b0; exp_busy[i] = 1'b0; exp_dout[i] = '0;
    end
    for (int i = 0; i < 16; i++) mm[i] = '0;

    rst = 1'b1; ren = 1'b0; baddr = '0; lwen = 1'b0; laddr = '0; ldata = '0;

    // Preload every block under reset so no entry is left undefined.
    for (int i = 0; i < 16; i++) load(4'(i), {$urandom, $urandom, $urandom, $urandom});
    load(4'd3, D_AA);
    load(4'd2, ONES);
    load(4'd7, D_7);
    load(4'd8, D_8);
    rst = 1'b0;
    step();
    check("reset_ready", {127'd0, bus_a.memReadReady}, 128'd0);
    check("reset_dout",  bus_a.memDout, 128'd0);
    check("reset_busy",  {127'd0, bus_a.busy}, 128'd0);

    // 1: basic read of block 3 with LATENCY 10.
    ren = 1'b1; baddr = 4'd3;
    step();
    wait_ready_a(k);
    check("t1_latency", 128'(k), 128'(LAT_A));
    check("t1_data", bus_a.memDout, D_AA);
    repeat (3) step();
    check("t1_hold", bus_a.memDout, D_AA);
    ren = 1'b0;
    step();
    check("t1_clear_rdy", {127'd0, bus_a.memReadReady}, 128'd0);
    check("t1_clear_dout", bus_a.memDout, 128'd0);

    // 2: address change during BUSY is ignored; busy lasts exactly LATENCY cycles.
    ren = 1'b1; baddr = 4'hF;
    step();
    baddr = 4'h1;
    k = (bus_a.busy) ? 1 : 0;
    for (int i = 0; i < 40 && !bus_a.memReadReady; i++) begin
      step();
      if (bus_a.busy) k++;
    end
    check("t2_busy_cycles", 128'(k), 128'(LAT_A));
    check("t2_data", bus_a.memDout, mm[15]);
    ren = 1'b0;
    step();

    // 3: abort after 4 cycles, then a full request.
    ren = 1'b1; baddr = 4'd5;
    seen = 1'b0;
    repeat (4) begin
      step();
      seen |= bus_a.memReadReady;
    end
    ren = 1'b0;
    repeat (3) begin
      step();
      seen |= bus_a.memReadReady;
    end
    check("t3_no_ready", {127'd0, seen}, 128'd0);
    ren = 1'b1;
    step();
    wait_ready_a(k);
    check("t3_latency", 128'(k), 128'(LAT_A));
    check("t3_data", bus_a.memDout, mm[5]);
    ren = 1'b0;
    step();

    // 4a: reset while BUSY.
    ren = 1'b1; baddr = 4'd3;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("t4a_ready", {127'd0, bus_a.memReadReady}, 128'd0);
    check("t4a_busy",  {127'd0, bus_a.busy}, 128'd0);
    check("t4a_dout",  bus_a.memDout, 128'd0);
    rst = 1'b0;
    step();
    wait_ready_a(k);
    check("t4a_latency", 128'(k), 128'(LAT_A));
    check("t4a_data", bus_a.memDout, D_AA);
    // 4b: reset while READY.
    rst = 1'b1;
    step();
    check("t4b_ready", {127'd0, bus_a.memReadReady}, 128'd0);
    check("t4b_dout",  bus_a.memDout, 128'd0);
    rst = 1'b0; ren = 1'b0;
    step();

    // 5: load on the capture edge returns old data; the next read sees the new data.
    ren = 1'b1; baddr = 4'd2;
    step();
    repeat (LAT_A - 1) step();
    load(4'd2, 128'd0);
    check("t5_old_rdy", {127'd0, bus_a.memReadReady}, 128'd1);
    check("t5_old_data", bus_a.memDout, ONES);
    ren = 1'b0;
    step();
    ren = 1'b1;
    step();
    wait_ready_a(k);
    check("t5_new_data", bus_a.memDout, 128'd0);
    ren = 1'b0;
    repeat (2) step();

    // 6: LATENCY=1 instance, two requests separated by a single IDLE cycle.
    tbl[0] = '{1'b1, 4'd7, 1'b0, 1'b1, 128'd0};
    tbl[1] = '{1'b1, 4'd7, 1'b1, 1'b0, D_7};
    tbl[2] = '{1'b1, 4'd2, 1'b1, 1'b0, D_7};
    tbl[3] = '{1'b0, 4'd7, 1'b0, 1'b0, 128'd0};
    tbl[4] = '{1'b1, 4'd8, 1'b0, 1'b1, 128'd0};
    tbl[5] = '{1'b1, 4'd8, 1'b1, 1'b0, D_8};
    tbl[6] = '{1'b0, 4'd8, 1'b0, 1'b0, 128'd0};
    tbl[7] = '{1'b0, 4'd0, 1'b0, 1'b0, 128'd0};
    for (int i = 0; i < 8; i++) begin
      ren = tbl[i].ren; baddr = tbl[i].addr;
      step();
      check($sformatf("t6_ready[%0d]", i), {127'd0, bus_b.memReadReady}, {127'd0, tbl[i].rdy});
      check($sformatf("t6_busy[%0d]", i),  {127'd0, bus_b.busy},         {127'd0, tbl[i].busy});
      check($sformatf("t6_dout[%0d]", i),  bus_b.memDout,                tbl[i].dout);
    end

    // Random traffic: long-held requests, drops, stray loads and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if (ren) ren = ($urandom_range(11) != 0);
      else     ren = ($urandom_range(2) == 0);
      baddr = 4'($urandom);
      lwen  = ($urandom_range(3) == 0);
      laddr = 4'($urandom);
      ldata = {$urandom, $urandom, $urandom, $urandom};
      rst   = ($urandom_range(79) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
